// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: one-cycle registered lookup, write-first
// forwarding on same-index update, and a CLEAR sweep that invalidates every entry.
module branch_target_buffer #(
    parameter int INDEX_WIDTH = 9,
    parameter int TAG_WIDTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_predict,
    output logic        hit,
    output logic [31:0] target,
    output logic        ready,
    input  logic        update_valid,
    input  logic [31:0] pc_update,
    input  logic [31:0] target_update,
    input  logic        taken_update,
    input  logic        flush
);
    // state    | meaning
    // ST_CLEAR | sweeping valid bits, one index per cycle; lookups miss, updates dropped
    // ST_RUN   | table usable; lookups and taken updates active
    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam int TAG_LO = INDEX_WIDTH + 2;
    localparam int TAG_HI = INDEX_WIDTH + TAG_WIDTH + 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]             state_q;
    logic [INDEX_WIDTH-1:0] clr_cnt_q;
    logic [DEPTH-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]   tag_mem [DEPTH];
    logic [29:0]            tgt_mem [DEPTH];
    logic                   hit_q;
    logic [29:0]            target_q;

    logic [INDEX_WIDTH-1:0] lk_idx;
    logic [INDEX_WIDTH-1:0] up_idx;
    logic [TAG_WIDTH-1:0]   lk_tag;
    logic [TAG_WIDTH-1:0]   up_tag;
    logic                   wr_en;
    logic                   fwd;
    logic                   hit_next;
    logic [29:0]            tgt_next;

    assign lk_idx = pc_predict[INDEX_WIDTH+1:2];
    assign up_idx = pc_update[INDEX_WIDTH+1:2];
    assign lk_tag = pc_predict[TAG_HI:TAG_LO];
    assign up_tag = pc_update[TAG_HI:TAG_LO];

    // A flush or reset on the same edge wins over any pending update.
    assign wr_en = (state_q == ST_RUN) && update_valid && taken_update && !flush && !rst;
    assign fwd   = wr_en && (up_idx == lk_idx);

    always_comb begin
        hit_next = 1'b0;
        tgt_next = '0;
        if (fwd) begin
            hit_next = (up_tag == lk_tag);
            tgt_next = target_update[31:2];
        end else begin
            hit_next = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
            tgt_next = tgt_mem[lk_idx];
        end
        if (state_q != ST_RUN) begin
            hit_next = 1'b0;
        end
        if (!hit_next) begin
            tgt_next = '0;
        end
    end

    // Payload storage carries no reset; only valid bits gate its use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[up_idx] <= up_tag;
            tgt_mem[up_idx] <= target_update[31:2];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                valid_q[clr_cnt_q] <= 1'b0;
            end else if (wr_en) begin
                valid_q[up_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            hit_q     <= 1'b0;
            target_q  <= '0;
        end else begin
            hit_q    <= hit_next;
            target_q <= tgt_next;
            case (state_q)
                ST_CLEAR: begin
                    if (flush) begin
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                        if (clr_cnt_q == '1) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_cnt_q <= '0;
                end
            endcase
        end
    end

    assign hit    = hit_q;
    assign target = {target_q, 2'b00};
    assign ready  = (state_q == ST_RUN);

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_predict[31:TAG_HI+1], pc_predict[1:0],
                              pc_update[31:TAG_HI+1], pc_update[1:0], target_update[1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer with a 16-entry table and 8-bit tags.
module tb_branch_target_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_predict;
    logic        hit;
    logic [31:0] target;
    logic        ready;
    logic        update_valid;
    logic [31:0] pc_update;
    logic [31:0] target_update;
    logic        taken_update;
    logic        flush;

    int errors = 0;
    int checks = 0;

    branch_target_buffer #(.INDEX_WIDTH(4), .TAG_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .pc_predict(pc_predict),
        .hit(hit),
        .target(target),
        .ready(ready),
        .update_valid(update_valid),
        .pc_update(pc_update),
        .target_update(target_update),
        .taken_update(taken_update),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_predict = 32'h40; update_valid = 1'b0; pc_update = '0;
        target_update = '0; taken_update = 1'b0; flush = 1'b0;
        step(); step();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready actual=%b required=0", ready); end
        checks++;
        if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit actual=%b required=0", hit); end
        checks++;
        if (target !== 32'h0) begin errors++; $display("FAIL reset_target actual=%h required=0", target); end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ready !== 1'b0 || hit !== 1'b0) begin
                errors++; $display("FAIL clear_sweep cycle=%0d ready=%b hit=%b required 0/0", i, ready, hit);
            end
            step();
        end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_rise actual=%b required=1", ready); end
        checks++;
        if (hit !== 1'b0) begin errors++; $display("FAIL first_run_hit actual=%b required=0", hit); end
        step();
        checks++;
        if (hit !== 1'b0 || target !== 32'h0) begin
            errors++; $display("FAIL empty_lookup hit=%b target=%h required 0/0", hit, target);
        end
    endtask

    task automatic test_update();
        pc_predict = 32'h3C;
        update_valid = 1'b1; pc_update = 32'h40; target_update = 32'h103; taken_update = 1'b1;
        step();
        update_valid = 1'b0; pc_predict = 32'h40;
        step();
        checks++;
        if (hit !== 1'b1 || target !== 32'h100) begin
            errors++; $display("FAIL update_hit hit=%b target=%h required 1/00000100", hit, target);
        end
    endtask

    task automatic test_miss_and_not_taken();
        pc_predict = 32'h80;
        step();
        checks++;
        if (hit !== 1'b0 || target !== 32'h0) begin
            errors++; $display("FAIL tag_miss hit=%b target=%h required 0/0", hit, target);
        end
        pc_predict = 32'h3C;
        update_valid = 1'b1; pc_update = 32'h40; target_update = 32'h500; taken_update = 1'b0;
        step();
        update_valid = 1'b0; pc_predict = 32'h40;
        step();
        checks++;
        if (hit !== 1'b1 || target !== 32'h100) begin
            errors++; $display("FAIL not_taken_kept hit=%b target=%h required 1/00000100", hit, target);
        end
        pc_predict = 32'hFFFC_0040;
        step();
        checks++;
        if (hit !== 1'b1 || target !== 32'h100) begin
            errors++; $display("FAIL upper_bits_ignored hit=%b target=%h required 1/00000100", hit, target);
        end
    endtask

    task automatic test_back_to_back();
        pc_predict = 32'h44;
        update_valid = 1'b1; pc_update = 32'h44; target_update = 32'h200; taken_update = 1'b1;
        step();
        update_valid = 1'b0;
        checks++;
        if (hit !== 1'b1 || target !== 32'h200) begin
            errors++; $display("FAIL forward_hit hit=%b target=%h required 1/00000200", hit, target);
        end
        step();
        checks++;
        if (hit !== 1'b1 || target !== 32'h200) begin
            errors++; $display("FAIL stored_hit hit=%b target=%h required 1/00000200", hit, target);
        end
        update_valid = 1'b1; pc_update = 32'h84; target_update = 32'h603; taken_update = 1'b1;
        step();
        update_valid = 1'b0;
        checks++;
        if (hit !== 1'b0 || target !== 32'h0) begin
            errors++; $display("FAIL forward_tag_miss hit=%b target=%h required 0/0", hit, target);
        end
        pc_predict = 32'h84;
        step();
        checks++;
        if (hit !== 1'b1 || target !== 32'h600) begin
            errors++; $display("FAIL overwrite_hit hit=%b target=%h required 1/00000600", hit, target);
        end
    endtask

    task automatic test_flush();
        pc_predict = 32'h3C;
        flush = 1'b1;
        update_valid = 1'b1; pc_update = 32'h48; target_update = 32'h300; taken_update = 1'b1;
        step();
        flush = 1'b0; update_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ready !== 1'b0) begin
                errors++; $display("FAIL flush_sweep cycle=%0d ready=%b required=0", i, ready);
            end
            if (i == 15) begin
                update_valid = 1'b1; pc_update = 32'h4C; target_update = 32'h400; taken_update = 1'b1;
            end
            step();
            update_valid = 1'b0;
        end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready actual=%b required=1", ready); end
        pc_predict = 32'h40;
        step();
        checks++;
        if (hit !== 1'b0) begin errors++; $display("FAIL flushed_40 hit=%b required=0", hit); end
        pc_predict = 32'h44;
        step();
        checks++;
        if (hit !== 1'b0) begin errors++; $display("FAIL flushed_44 hit=%b required=0", hit); end
        pc_predict = 32'h48;
        step();
        checks++;
        if (hit !== 1'b0) begin errors++; $display("FAIL flushed_48 hit=%b required=0", hit); end
        pc_predict = 32'h4C;
        step();
        checks++;
        if (hit !== 1'b0) begin errors++; $display("FAIL clear_update_dropped hit=%b required=0", hit); end
    endtask

    task automatic test_reset_mid_clear();
        pc_predict = 32'h3C;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ready !== 1'b0) begin
                errors++; $display("FAIL reset_mid_clear cycle=%0d ready=%b required=0", i, ready);
            end
            step();
        end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_mid_clear_ready actual=%b required=1", ready); end
    endtask

    initial begin
        test_reset();
        test_update();
        test_miss_and_not_taken();
        test_back_to_back();
        test_flush();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
